// File: rtl/seq_detect_pkg.sv
// Shared constants, scheduler state type and index-width helper for the
// time-shared serial pattern detector.
package seq_detect_pkg;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;
    localparam int         DEFAULT_CNT_W   = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_e;

    // Width of a channel index; never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_detect_rr_arb.sv
// Round-robin arbiter: picks the first eligible channel at or after ptr,
// returning a one-hot grant, the granted index and a found flag.
module seq_detect_rr_arb
    import seq_detect_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IW  = idx_w(NCH)
) (
    input  logic [NCH-1:0] eligible,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  idx,
    output logic           found
);

    logic [IW-1:0] cand;

    // NOTE: every output gets a default before the search loop so that no
    // path through this block can leave a value unassigned and infer a latch.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 0; off < NCH; off++) begin
            cand = IW'((int'(ptr) + off) % NCH);
            if (!found && eligible[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin time-shared overlapping pattern detector with a saved
// three-bit history and fill count per channel.
module seq_detect_sched
    import seq_detect_pkg::*;
#(
    parameter int         NCH     = 4,
    parameter logic [3:0] PATTERN = DEFAULT_PATTERN,
    parameter int         CNT_W   = DEFAULT_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [NCH-1:0]         req,
    input  logic [NCH-1:0]         bit_in,
    input  logic [NCH-1:0]         clr,
    output logic [NCH-1:0]         gnt,
    output logic                   seen,
    output logic [idx_w(NCH)-1:0]  seen_ch,
    output logic [CNT_W-1:0]       hit_cnt
);

    localparam int IW = idx_w(NCH);

    sched_state_e   state, state_next;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  gnt_idx;
    logic           found;
    logic           match;
    logic           hit_q;
    logic [NCH-1:0] eligible;
    logic [2:0]     ctx_hist [NCH];
    logic [1:0]     ctx_fill [NCH];

    // Gating with reset keeps gnt low for the whole time reset is asserted.
    assign eligible = req & ~clr & {NCH{en & reset}};

    seq_detect_rr_arb #(.NCH(NCH), .IW(IW)) u_arb (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .gnt      (gnt),
        .idx      (gnt_idx),
        .found    (found)
    );

    always_comb begin
        state_next = IDLE;
        match      = 1'b0;
        if (found) begin
            state_next = GRANT;
            match      = (ctx_fill[gnt_idx] == 2'd3) &&
                         ({ctx_hist[gnt_idx], bit_in[gnt_idx]} == PATTERN);
        end
    end

    // NOTE: all state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            hit_q <= 1'b0;
        end else begin
            state <= state_next;
            hit_q <= match;
        end
    end

    assign seen = (state == GRANT) && hit_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr  <= '0;
            seen_ch <= '0;
            hit_cnt <= '0;
        end else if (found) begin
            rr_ptr <= (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
            if (match) begin
                seen_ch <= gnt_idx;
                if (hit_cnt != '1)
                    hit_cnt <= hit_cnt + 1'b1;
            end
        end
    end

    // NOTE: the context store is reset explicitly because a mid-stream reset
    // must discard partial matches; it is small enough to stay in flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                ctx_hist[i] <= '0;
                ctx_fill[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr[i]) begin
                    ctx_hist[i] <= '0;
                    ctx_fill[i] <= '0;
                end else if (gnt[i]) begin
                    ctx_hist[i] <= {ctx_hist[i][1:0], bit_in[i]};
                    if (ctx_fill[i] != 2'd3)
                        ctx_fill[i] <= ctx_fill[i] + 2'd1;
                end
            end
        end
    end

endmodule
